axis_to_sample_adapter: RTL and testbench
=========================================

AXIS_TO_SAMPLE_ADAPTER -- requirements
Module: axis_to_sample_adapter

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 12: bits per I and per Q component.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 8: AXI stream beat width.
REQ-003 SHALL have a derived localparam BEATS = ceil(2*SAMPLE_WIDTH/AXI_DATA_WIDTH), which is 3 at the defaults.
REQ-004 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port s_axis_tdata, input, AXI_DATA_WIDTH bits: byte stream input.
REQ-007 SHALL have port s_axis_tvalid, input, 1 bit: input beat valid.
REQ-008 SHALL have port s_axis_tready, output, 1 bit: input beat ready.
REQ-009 SHALL have port s_axis_tlast, input, 1 bit: last beat of a sample.
REQ-010 SHALL have port s_axis_tuser, input, 1 bit: bad-frame marker.
REQ-011 SHALL have port I_out, output, SAMPLE_WIDTH bits: reassembled I component.
REQ-012 SHALL have port Q_out, output, SAMPLE_WIDTH bits: reassembled Q component.
REQ-013 SHALL have port output_valid, output, 1 bit: one-cycle strobe marking a new sample.
REQ-014 SHALL have port sync_err, output, 1 bit: one-cycle strobe on a framing error.

Function
REQ-015 SHALL accept a beat when s_axis_tvalid and s_axis_tready are both high.
REQ-016 SHALL keep s_axis_tready high in every cycle except reset cycles, because the sample side applies no backpressure.
REQ-017 SHALL keep a beat counter beat_cnt in the range 0..BEATS-1, increment it on each accepted beat, and wrap it to 0 after beat BEATS-1.
REQ-018 SHALL order beats least-significant first: beat k fills word bits [k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH], where word = {I, Q}.
REQ-019 SHALL discard padding bits of the final beat that lie above 2*SAMPLE_WIDTH.
REQ-020 SHALL register I_out = word[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH] and Q_out = word[SAMPLE_WIDTH-1:0], and pulse output_valid, in the cycle after beat BEATS-1 is accepted (latency 1 cycle from final beat).
REQ-021 SHALL hold I_out and Q_out at their values between strobes.
REQ-022 SHALL drop the sample when s_axis_tuser is high on any beat of it: no output_valid, beat_cnt returns to 0 after that sample's final beat or tlast.
REQ-023 SHALL leave state unchanged on cycles with s_axis_tvalid low, so gaps between beats are allowed.
REQ-024 SHALL sustain one beat per cycle, giving one sample per BEATS cycles.

Reset
REQ-025 SHALL, while rst is high, force beat_cnt=0, I_out=0, Q_out=0, output_valid=0, sync_err=0 and s_axis_tready=0.
REQ-026 SHALL discard any partially assembled sample when rst is asserted mid-sample.
REQ-027 SHALL treat the first beat accepted after reset as beat 0.

Configuration
REQ-028 SHALL implement tlast resynchronisation under macro AXIS_TO_SAMPLE_TLAST_RESYNC_EN.
REQ-029 SHALL, with AXIS_TO_SAMPLE_TLAST_RESYNC_EN defined and tlast high on a beat with beat_cnt < BEATS-1: discard the partial sample, set beat_cnt=0, pulse sync_err the next cycle, and suppress output_valid.
REQ-030 SHALL, with AXIS_TO_SAMPLE_TLAST_RESYNC_EN defined and tlast low on beat BEATS-1: still emit the sample and also pulse sync_err in the same cycle as output_valid.
REQ-031 SHALL, without AXIS_TO_SAMPLE_TLAST_RESYNC_EN: ignore s_axis_tlast and tie sync_err to 0.

Structure
REQ-032 SHALL place in shared package sample_axis_pkg: the default SAMPLE_WIDTH and AXI_DATA_WIDTH constants and the beats-per-sample ceil-divide function, shared with the transmit-side adapter.
REQ-033 SHALL be a single module with no sub-module; the assembly logic is too small to warrant splitting.

Verification
REQ-034 SHALL cover: beats 0x56, 0x34, 0x12 with tlast on the 3rd -> next cycle output_valid=1, I_out=0x123, Q_out=0x456.
REQ-035 SHALL cover: 4 samples back-to-back with tvalid held high -> output_valid strobes every 3 cycles with the correct values and no sync_err.
REQ-036 SHALL cover: tvalid toggling between beats of 0xFF, 0x0F, 0x80 -> I_out=0x800, Q_out=0xFFF, output emitted exactly once.
REQ-037 SHALL cover: rst pulsed after 2 beats, then 0x21, 0x43, 0x65 -> only one output, I_out=0x654, Q_out=0x321.
REQ-038 SHALL cover, with RESYNC_EN defined: tlast on beat 2 of 3 -> sync_err pulse, no output_valid; the following clean sample decodes correctly.
REQ-039 SHALL cover: tuser high on beat 1 -> that sample dropped; the next sample is emitted normally.

Source files
------------

// File: rtl/sample_axis_pkg.sv
// Shared constants and helpers for the AXI-stream <-> I/Q sample adapters.
// Used by both the receive-side (axis_to_sample_adapter) and transmit-side blocks.
package sample_axis_pkg;

  localparam int DEFAULT_SAMPLE_WIDTH   = 12;
  localparam int DEFAULT_AXI_DATA_WIDTH = 8;

  // Number of stream beats needed to carry one {I, Q} sample (ceil divide).
  function automatic int beats_per_sample(input int sample_width, input int axi_data_width);
    return (2 * sample_width + axi_data_width - 1) / axi_data_width;
  endfunction

endpackage

// File: rtl/axis_to_sample_adapter.sv
// Reassembles {I, Q} samples from a narrow AXI stream, least-significant beat first.
// Beats carrying tuser=1 poison the whole sample, which is then dropped.
// Optional tlast framing check / resynchronisation: AXIS_TO_SAMPLE_TLAST_RESYNC_EN.
// Requires at least two beats per sample.
module axis_to_sample_adapter
  import sample_axis_pkg::*;
#(
  parameter int SAMPLE_WIDTH   = DEFAULT_SAMPLE_WIDTH,
  parameter int AXI_DATA_WIDTH = DEFAULT_AXI_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  input  logic                      s_axis_tuser,
  output logic [SAMPLE_WIDTH-1:0]   I_out,
  output logic [SAMPLE_WIDTH-1:0]   Q_out,
  output logic                      output_valid,
  output logic                      sync_err
);

  localparam int BEATS  = beats_per_sample(SAMPLE_WIDTH, AXI_DATA_WIDTH);
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int HELD_W = (BEATS - 1) * AXI_DATA_WIDTH;
  localparam int WORD_W = 2 * SAMPLE_WIDTH;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]        beat_cnt_reg;
  logic                    bad_reg;
  logic [HELD_W-1:0]       held_reg;
  logic [SAMPLE_WIDTH-1:0] i_reg;
  logic [SAMPLE_WIDTH-1:0] q_reg;
  logic                    output_valid_reg;
  logic                    sync_err_reg;

  logic              accept;
  logic              is_last;
  logic              sample_bad;
  logic              early_last;
  logic              missing_last;
  logic [BEATS-2:0]  lane_we;
  logic [WORD_W-1:0] sample_word;

  // The sample side never stalls, so the stream is only held off during reset.
  assign s_axis_tready = ~rst;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign is_last       = (beat_cnt_reg == LAST_BEAT);
  assign sample_bad    = bad_reg | s_axis_tuser;

  // The final beat is used straight from the bus; padding above 2*SAMPLE_WIDTH is cut off by the cast.
  assign sample_word = WORD_W'({s_axis_tdata, held_reg});

  // One write enable per buffered lane (all beats except the final one).
  for (genvar gi = 0; gi < BEATS - 1; gi++) begin : g_lane_we
    assign lane_we[gi] = accept && (beat_cnt_reg == CNT_W'(gi));
  end

`ifdef AXIS_TO_SAMPLE_TLAST_RESYNC_EN
  // tlast before the final beat restarts framing; a final beat without tlast is flagged.
  assign early_last   = accept & s_axis_tlast & ~is_last;
  assign missing_last = accept & ~s_axis_tlast & is_last;
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign early_last   = 1'b0;
  assign missing_last = 1'b0;
`endif

  // Beat buffer: capture the lower beats of the sample in their word positions.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_reg <= '0;
    end else begin
      for (int k = 0; k < BEATS - 1; k++) begin
        if (lane_we[k]) begin
          held_reg[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= s_axis_tdata;
        end
      end
    end
  end

  // Framing counter, bad-sample tracking and registered sample output.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_reg     <= '0;
      bad_reg          <= 1'b0;
      i_reg            <= '0;
      q_reg            <= '0;
      output_valid_reg <= 1'b0;
      sync_err_reg     <= 1'b0;
    end else begin
      output_valid_reg <= 1'b0;
      sync_err_reg     <= early_last | missing_last;
      if (accept) begin
        if (is_last || early_last) begin
          beat_cnt_reg <= '0;
          bad_reg      <= 1'b0;
        end else begin
          beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
          bad_reg      <= sample_bad;
        end
        if (is_last && !sample_bad) begin
          i_reg            <= sample_word[WORD_W-1:SAMPLE_WIDTH];
          q_reg            <= sample_word[SAMPLE_WIDTH-1:0];
          output_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign I_out        = i_reg;
  assign Q_out        = q_reg;
  assign output_valid = output_valid_reg;
  assign sync_err     = sync_err_reg;

endmodule

// File: tb/tb_axis_to_sample_adapter.sv
// Self-checking bench for axis_to_sample_adapter (default 12-bit samples over 8-bit beats).
// Expected samples are queued as stimulus is driven and matched when output_valid strobes.
module tb_axis_to_sample_adapter;

  localparam int SW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic          s_axis_tuser;
  logic [SW-1:0] I_out;
  logic [SW-1:0] Q_out;
  logic          output_valid;
  logic          sync_err;

  always #5 clk = ~clk;

  axis_to_sample_adapter #(
    .SAMPLE_WIDTH   (SW),
    .AXI_DATA_WIDTH (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .I_out         (I_out),
    .Q_out         (Q_out),
    .output_valid  (output_valid),
    .sync_err      (sync_err)
  );

  typedef struct {
    logic [SW-1:0] i;
    logic [SW-1:0] q;
    logic          se;
  } exp_t;

  typedef struct {
    logic [7:0]    b0;
    logic [7:0]    b1;
    logic [7:0]    b2;
    int            user_idx;
    int            last_idx;
    int            gap;
    bit            emit;
    logic [SW-1:0] exp_i;
    logic [SW-1:0] exp_qv;
    logic          se;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int se_count = 0;
  int exp_se_total = 0;
  bit spacing_on = 1'b0;
  int prev_ov_cyc = -1;
  logic [SW-1:0] last_i = '0;
  logic [SW-1:0] last_q = '0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endfunction

  // Scoreboard monitor: every output strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    cyc++;
    if (rst === 1'b0) begin
      if (output_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got I=0x%0h Q=0x%0h, required no output", I_out, Q_out);
        end else begin
          mon_e = sb_q.pop_front();
          check("I_out", 32'(I_out), 32'(mon_e.i));
          check("Q_out", 32'(Q_out), 32'(mon_e.q));
          check("sync_err_with_output", 32'(sync_err), 32'(mon_e.se));
          $display("sample out: I=0x%03h Q=0x%03h sync_err=%0b", I_out, Q_out, sync_err);
          last_i = mon_e.i;
          last_q = mon_e.q;
        end
        if (spacing_on) begin
          if (prev_ov_cyc >= 0) check("strobe_spacing", 32'(cyc - prev_ov_cyc), 32'd3);
          prev_ov_cyc = cyc;
        end
      end
      if (sync_err === 1'b1) se_count++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive the three beats of one sample; queue its expected output with the final beat.
  task automatic send_sample(input vec_t v);
    logic [7:0] b [3];
    b[0] = v.b0; b[1] = v.b1; b[2] = v.b2;
    for (int k = 0; k < 3; k++) begin
      s_axis_tdata  = b[k];
      s_axis_tuser  = (k == v.user_idx);
      s_axis_tlast  = (k == v.last_idx);
      s_axis_tvalid = 1'b1;
      if (k == 2 && v.emit) sb_q.push_back('{i: v.exp_i, q: v.exp_qv, se: v.se});
      @(posedge clk);
      #1;
      if (v.gap > 0) begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tdata  = 8'($urandom);
        repeat (v.gap) @(posedge clk);
        #1;
      end
    end
  endtask

  function automatic vec_t mk(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input int user_idx, input int last_idx, input int gap, input bit emit,
                              input logic [SW-1:0] ei, input logic [SW-1:0] eq, input logic se);
    vec_t v;
    v.b0 = b0; v.b1 = b1; v.b2 = b2;
    v.user_idx = user_idx; v.last_idx = last_idx; v.gap = gap; v.emit = emit;
    v.exp_i = ei; v.exp_qv = eq; v.se = se;
    return v;
  endfunction

  localparam int NV = 8;
  vec_t vecs [NV];

  initial begin
    logic [23:0] word;
    vec_t v;

    vecs[0] = mk(8'h56, 8'h34, 8'h12, -1, 2, 0, 1'b1, 12'h123, 12'h456, 1'b0);
    vecs[1] = mk(8'hFF, 8'h0F, 8'h80, -1, 2, 2, 1'b1, 12'h800, 12'hFFF, 1'b0);
    vecs[2] = mk(8'hAA, 8'hBB, 8'hCC, -1, 2, 1, 1'b1, 12'hCCB, 12'hBAA, 1'b0);
    vecs[3] = mk(8'h00, 8'h00, 8'h00, -1, 2, 0, 1'b1, 12'h000, 12'h000, 1'b0);
    vecs[4] = mk(8'hFF, 8'hFF, 8'hFF, -1, 2, 0, 1'b1, 12'hFFF, 12'hFFF, 1'b0);
    vecs[5] = mk(8'hEF, 8'hBE, 8'hAD,  1, 2, 0, 1'b0, 12'h000, 12'h000, 1'b0);
    vecs[6] = mk(8'h01, 8'h23, 8'h45, -1, 2, 0, 1'b1, 12'h452, 12'h301, 1'b0);
    vecs[7] = mk(8'h5A, 8'hA5, 8'hC3,  2, 2, 0, 1'b0, 12'h000, 12'h000, 1'b0);

    rst = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tready", 32'(s_axis_tready), 32'd0);
    check("reset_output_valid", 32'(output_valid), 32'd0);
    check("reset_sync_err", 32'(sync_err), 32'd0);
    check("reset_I_out", 32'(I_out), 32'd0);
    check("reset_Q_out", 32'(Q_out), 32'd0);
    rst = 1'b0;
    #1;
    check("tready_after_reset", 32'(s_axis_tready), 32'd1);

    // Table of single samples, with gaps, drops and boundary patterns.
    for (int n = 0; n < NV; n++) begin
      send_sample(vecs[n]);
      idle(4);
    end

    // Back-to-back samples with tvalid held high: one strobe every three cycles.
    spacing_on = 1'b1;
    prev_ov_cyc = -1;
    for (int n = 0; n < 4; n++) begin
      word = 24'($urandom);
      send_sample(mk(word[7:0], word[15:8], word[23:16], -1, 2, 0, 1'b1,
                     word[23:12], word[11:0], 1'b0));
    end
    idle(5);
    spacing_on = 1'b0;

    // Reset in the middle of a sample discards the partial beats.
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'h11;
    @(posedge clk); #1;
    s_axis_tdata = 8'h22;
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midreset_tready", 32'(s_axis_tready), 32'd0);
    check("midreset_I_out", 32'(I_out), 32'd0);
    check("midreset_Q_out", 32'(Q_out), 32'd0);
    rst = 1'b0;
    send_sample(mk(8'h21, 8'h43, 8'h65, -1, 2, 0, 1'b1, 12'h654, 12'h321, 1'b0));
    idle(4);

`ifdef AXIS_TO_SAMPLE_TLAST_RESYNC_EN
    // tlast on the second beat: framing restarts, sync_err pulses, nothing emitted.
    s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0; s_axis_tdata = 8'h11;
    @(posedge clk); #1;
    s_axis_tlast = 1'b1; s_axis_tdata = 8'h22;
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    exp_se_total++;
    check("early_tlast_sync_err", 32'(sync_err), 32'd1);
    check("early_tlast_no_output", 32'(output_valid), 32'd0);
    send_sample(mk(8'h01, 8'h23, 8'h45, -1, 2, 0, 1'b1, 12'h452, 12'h301, 1'b0));
    idle(4);
    // Final beat without tlast: sample still emitted, flagged in the same cycle.
    exp_se_total++;
    send_sample(mk(8'h67, 8'h45, 8'h23, -1, -1, 0, 1'b1, 12'h234, 12'h567, 1'b1));
    idle(4);
`else
    // Without resynchronisation tlast is ignored, even on a middle beat.
    send_sample(mk(8'h10, 8'h32, 8'h54, -1, 1, 0, 1'b1, 12'h543, 12'h210, 1'b0));
    idle(4);
`endif

    for (int n = 0; n < 20 && sb_q.size() != 0; n++) idle(1);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    idle(6);
    check("I_out_hold", 32'(I_out), 32'(last_i));
    check("Q_out_hold", 32'(Q_out), 32'(last_q));
    check("sync_err_pulses", 32'(se_count), 32'(exp_se_total));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
